rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_seq_pkg.sv | 30 +++
 rtl/rst_seq_timer.sv | 38 +++
 rtl/rst_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer: FSM state encoding, default
// parameter values, and field widths for the channel index and retry count.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_HB_WIDTH       = 29;

  // Channel index covers up to 8 channels; retry count covers 0..15.
  localparam int IDX_W   = 3;
  localparam int RETRY_W = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// -----------------------------------------------------------------------------
// rst_seq_timer
// Loadable down-counter used for both the reset hold time and the done
// timeout. A load takes priority; otherwise the count decrements and sticks
// at zero.
//
// Ports:
//   clk       in   clock (rising edge)
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val on this edge
//   load_val  in   CNT_W value to load
//   zero      out  count is zero (interval elapsed)
// -----------------------------------------------------------------------------
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
// Releases NUM_CH downstream resets one at a time. Each channel reset is held
// HOLD_CYCLES, then released; the channel must report done within
// TIMEOUT_CYCLES or it is re-reset, up to MAX_RETRY times, before the
// sequence fails. A free-running counter drives a heartbeat.
//
// Optional feature: define RST_SEQ_DONE_MONITOR_EN to restart the whole
// sequence from channel 0 if any done bit drops while in DONE. Without it,
// done inputs are ignored once the sequence has completed.
//
// Ports:
//   sys_clk_i    in   clock (rising edge)
//   sys_rst_i    in   synchronous active-high reset
//   enable_i     in   high runs the sequence, low aborts to IDLE
//   ch_done_i    in   NUM_CH per-channel done (already synchronous)
//   ch_rst_o     out  NUM_CH per-channel active-high reset (registered)
//   all_done_o   out  all channels released and done
//   fail_o       out  sticky failure flag (cleared by enable_i low)
//   fail_ch_o    out  3-bit index of failing channel while fail_o is high
//   heartbeat_o  out  MSB of the free-running heartbeat counter
// -----------------------------------------------------------------------------
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int HB_WIDTH       = DEF_HB_WIDTH
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] ch_done_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              all_done_o,
  output logic              fail_o,
  output logic [2:0]        fail_ch_o,
  output logic              heartbeat_o
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("rst_sequencer: NUM_CH must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rst_sequencer: TIMEOUT_CYCLES must be >= 2");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
    $error("rst_sequencer: MAX_RETRY must be in 0..15");
  end
  if (HB_WIDTH < 2) begin : g_bad_hb
    $error("rst_sequencer: HB_WIDTH must be >= 2");
  end

  localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [RETRY_W-1:0]   retry, retry_nxt;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_zero;
  logic [7:0]           done_ext;
  logic [NUM_CH-1:0]    ch_rst_nxt;
  logic                 all_done_nxt;
  logic                 fail_nxt;
  logic [2:0]           fail_ch_nxt;
  logic [HB_WIDTH-1:0]  hb_cnt;

  rst_seq_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (sys_clk_i),
    .rst      (sys_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Pad done to 8 bits so idx can index it at its full width.
  always_comb begin
    done_ext               = '0;
    done_ext[NUM_CH-1:0]   = ch_done_i;
  end

  // State register; outputs are registered from next-state values so they
  // change on the same edge as the state they describe.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      retry      <= '0;
      ch_rst_o   <= '1;
      all_done_o <= 1'b0;
      fail_o     <= 1'b0;
      fail_ch_o  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      retry      <= retry_nxt;
      ch_rst_o   <= ch_rst_nxt;
      all_done_o <= all_done_nxt;
      fail_o     <= fail_nxt;
      fail_ch_o  <= fail_ch_nxt;
    end
  end

  // Next-state logic. HOLD loads HOLD_CYCLES and exits when the timer reads
  // zero, giving release on the (HOLD_CYCLES+1)th edge. WAIT loads
  // TIMEOUT_CYCLES-1 so the timeout lands exactly TIMEOUT_CYCLES edges after
  // release. Priority is enable low, then done, then timeout.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    tmr_load  = 1'b0;
    tmr_val   = TMR_W'(HOLD_CYCLES);
    if (state != ST_IDLE && !enable_i) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state_nxt = ST_HOLD;
            idx_nxt   = '0;
            retry_nxt = '0;
            tmr_load  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state_nxt = ST_WAIT;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(TIMEOUT_CYCLES - 1);
          end
        end
        ST_WAIT: begin
          if (done_ext[idx]) begin
            if (idx == IDX_W'(NUM_CH - 1)) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_HOLD;
              idx_nxt   = idx + IDX_W'(1);
              retry_nxt = '0;
              tmr_load  = 1'b1;
            end
          end else if (tmr_zero) begin
            if (retry < RETRY_W'(MAX_RETRY)) begin
              state_nxt = ST_HOLD;
              retry_nxt = retry + RETRY_W'(1);
              tmr_load  = 1'b1;
            end else begin
              state_nxt = ST_FAIL;
            end
          end
        end
        ST_DONE: begin
`ifdef RST_SEQ_DONE_MONITOR_EN
          if (!(&ch_done_i)) begin
            state_nxt = ST_HOLD;
            idx_nxt   = '0;
            retry_nxt = '0;
            tmr_load  = 1'b1;
          end
`endif
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // Output decode from next state: channels below idx are released, above
  // are held, and channel idx is released only while waiting for its done.
  always_comb begin
    ch_rst_nxt   = '1;
    all_done_nxt = (state_nxt == ST_DONE);
    fail_nxt     = (state_nxt == ST_FAIL);
    fail_ch_nxt  = (state_nxt == ST_FAIL) ? idx_nxt : 3'd0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (state_nxt == ST_IDLE) begin
        ch_rst_nxt[j] = 1'b1;
      end else if (state_nxt == ST_DONE) begin
        ch_rst_nxt[j] = 1'b0;
      end else if (IDX_W'(j) < idx_nxt) begin
        ch_rst_nxt[j] = 1'b0;
      end else if (IDX_W'(j) > idx_nxt) begin
        ch_rst_nxt[j] = 1'b1;
      end else begin
        ch_rst_nxt[j] = (state_nxt != ST_WAIT);
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + HB_WIDTH'(1);
    end
  end

  assign heartbeat_o = hb_cnt[HB_WIDTH-1];

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
// Directed bench for rst_sequencer with NUM_CH=3, HOLD_CYCLES=4,
// TIMEOUT_CYCLES=16, MAX_RETRY=2, HB_WIDTH=4. Inputs change 1 time unit after
// a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

  logic       sys_clk_i;
  logic       sys_rst_i;
  logic       enable_i;
  logic [2:0] ch_done_i;
  logic [2:0] ch_rst_o;
  logic       all_done_o;
  logic       fail_o;
  logic [2:0] fail_ch_o;
  logic       heartbeat_o;

  int errors = 0;
  int checks = 0;

  rst_sequencer #(
    .NUM_CH         (3),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (2),
    .HB_WIDTH       (4)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .enable_i    (enable_i),
    .ch_done_i   (ch_done_i),
    .ch_rst_o    (ch_rst_o),
    .all_done_o  (all_done_o),
    .fail_o      (fail_o),
    .fail_ch_o   (fail_ch_o),
    .heartbeat_o (heartbeat_o)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_i = 1'b1;
    enable_i  = 1'b0;
    ch_done_i = 3'b000;
    tick(2);

    // Reset state
    check("rst_ch_rst",   8'(ch_rst_o),   8'h07);
    check("rst_all_done", 8'(all_done_o), 8'h00);
    check("rst_fail",     8'(fail_o),     8'h00);
    check("rst_fail_ch",  8'(fail_ch_o),  8'h00);
    check("rst_hb",       8'(heartbeat_o), 8'h00);

    // Heartbeat: 0 while counter is 0..7, 1 while 8..15, then wraps
    sys_rst_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      check($sformatf("hb_k%0d", k), 8'(heartbeat_o), (k % 16 >= 8) ? 8'h01 : 8'h00);
    end
    check("idle_ch_rst", 8'(ch_rst_o), 8'h07);

    // Normal sequence: enable sampled at edge 0
    enable_i = 1'b1;
    tick(1);
    check("norm_e0", 8'(ch_rst_o), 8'h07);
    tick(4);
    check("norm_e4", 8'(ch_rst_o), 8'h07);
    tick(1);
    check("norm_e5_rel0", 8'(ch_rst_o), 8'h06);
    tick(1);
    ch_done_i = 3'b001;
    tick(1);
    check("norm_e7_hold1", 8'(ch_rst_o), 8'h06);
    tick(4);
    check("norm_e11", 8'(ch_rst_o), 8'h06);
    tick(1);
    check("norm_e12_rel1", 8'(ch_rst_o), 8'h04);
    tick(1);
    ch_done_i = 3'b011;
    tick(1);
    check("norm_e14_hold2", 8'(ch_rst_o), 8'h04);
    tick(5);
    check("norm_e19_rel2", 8'(ch_rst_o), 8'h00);
    check("norm_e19_nodone", 8'(all_done_o), 8'h00);
    tick(1);
    ch_done_i = 3'b111;
    tick(1);
    check("norm_all_done", 8'(all_done_o), 8'h01);
    check("norm_done_ch_rst", 8'(ch_rst_o), 8'h00);
    check("norm_done_fail", 8'(fail_o), 8'h00);

    // Done monitor: drop channel 1 done while in DONE
    ch_done_i = 3'b101;
    tick(1);
`ifdef RST_SEQ_DONE_MONITOR_EN
    check("mon_ch_rst", 8'(ch_rst_o), 8'h07);
    check("mon_all_done", 8'(all_done_o), 8'h00);
`else
    check("mon_ch_rst", 8'(ch_rst_o), 8'h00);
    check("mon_all_done", 8'(all_done_o), 8'h01);
`endif

    // Disable from DONE/HOLD returns to IDLE
    enable_i  = 1'b0;
    ch_done_i = 3'b000;
    tick(1);
    check("dis_ch_rst", 8'(ch_rst_o), 8'h07);
    check("dis_all_done", 8'(all_done_o), 8'h00);

    // Abort during HOLD of channel 1
    enable_i = 1'b1;
    tick(6);
    check("abort_rel0", 8'(ch_rst_o), 8'h06);
    tick(1);
    ch_done_i = 3'b001;
    tick(1);
    tick(2);
    check("abort_hold1", 8'(ch_rst_o), 8'h06);
    enable_i  = 1'b0;
    ch_done_i = 3'b000;
    tick(1);
    check("abort_ch_rst", 8'(ch_rst_o), 8'h07);
    tick(1);
    check("abort_idle", 8'(ch_rst_o), 8'h07);

    // Re-enable restarts at channel 0, then exercise one retry on channel 1
    enable_i = 1'b1;
    tick(1);
    check("reen_e0", 8'(ch_rst_o), 8'h07);
    tick(4);
    check("reen_e4", 8'(ch_rst_o), 8'h07);
    tick(1);
    check("reen_rel0", 8'(ch_rst_o), 8'h06);
    tick(1);
    ch_done_i = 3'b001;
    tick(1);
    check("retry_hold1", 8'(ch_rst_o), 8'h06);
    tick(5);
    check("retry_rel1", 8'(ch_rst_o), 8'h04);
    tick(15);
    check("retry_r15", 8'(ch_rst_o), 8'h04);
    tick(1);
    check("retry_reassert", 8'(ch_rst_o), 8'h06);
    check("retry_nofail", 8'(fail_o), 8'h00);
    tick(4);
    check("retry_r20", 8'(ch_rst_o), 8'h06);
    tick(1);
    check("retry_rerel", 8'(ch_rst_o), 8'h04);
    tick(1);
    ch_done_i = 3'b011;
    tick(1);
    check("retry_hold2", 8'(ch_rst_o), 8'h04);
    tick(5);
    check("retry_rel2", 8'(ch_rst_o), 8'h00);
    tick(1);
    ch_done_i = 3'b111;
    tick(1);
    check("retry_all_done", 8'(all_done_o), 8'h01);
    check("retry_fail", 8'(fail_o), 8'h00);
    enable_i  = 1'b0;
    ch_done_i = 3'b000;
    tick(1);
    check("retry_dis", 8'(ch_rst_o), 8'h07);

    // Fail: channel 2 never reports done
    enable_i = 1'b1;
    tick(6);
    check("fail_rel0", 8'(ch_rst_o), 8'h06);
    tick(1);
    ch_done_i = 3'b001;
    tick(6);
    check("fail_rel1", 8'(ch_rst_o), 8'h04);
    tick(1);
    ch_done_i = 3'b011;
    tick(6);
    check("fail_rel2_a", 8'(ch_rst_o), 8'h00);
    tick(16);
    check("fail_reassert_a", 8'(ch_rst_o), 8'h04);
    tick(5);
    check("fail_rel2_b", 8'(ch_rst_o), 8'h00);
    tick(16);
    check("fail_reassert_b", 8'(ch_rst_o), 8'h04);
    tick(5);
    check("fail_rel2_c", 8'(ch_rst_o), 8'h00);
    tick(15);
    check("fail_before", 8'(fail_o), 8'h00);
    tick(1);
    check("fail_flag", 8'(fail_o), 8'h01);
    check("fail_ch", 8'(fail_ch_o), 8'h02);
    check("fail_ch_rst", 8'(ch_rst_o), 8'h04);
    tick(3);
    check("fail_sticky", 8'(fail_o), 8'h01);
    enable_i  = 1'b0;
    ch_done_i = 3'b000;
    tick(1);
    check("fail_exit_ch_rst", 8'(ch_rst_o), 8'h07);
    check("fail_exit_flag", 8'(fail_o), 8'h00);
    check("fail_exit_ch", 8'(fail_ch_o), 8'h00);

    // Done and timeout on the same edge count as done
    enable_i = 1'b1;
    tick(6);
    check("prio_rel0", 8'(ch_rst_o), 8'h06);
    tick(15);
    check("prio_e20", 8'(ch_rst_o), 8'h06);
    ch_done_i = 3'b001;
    tick(1);
    check("prio_done_wins", 8'(ch_rst_o), 8'h06);
    tick(5);
    check("prio_rel1", 8'(ch_rst_o), 8'h04);

    // Reset mid-sequence overrides enable and done
    ch_done_i = 3'b011;
    sys_rst_i = 1'b1;
    tick(1);
    check("midrst_ch_rst", 8'(ch_rst_o), 8'h07);
    check("midrst_all_done", 8'(all_done_o), 8'h00);
    check("midrst_hb", 8'(heartbeat_o), 8'h00);
    sys_rst_i = 1'b0;
    ch_done_i = 3'b000;
    tick(6);
    check("midrst_restart", 8'(ch_rst_o), 8'h06);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
